hazard_scoreboard: RTL and testbench

//  Parametrised successor to the pipeline's combinational stall logic. Sits beside the F/D and D/X latches.

---
 rtl/hazard_pkg.sv | 53 +++++
 rtl/reg_scoreboard.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Instruction field layout, opcode constants and a shared decoder used by
// the hazard scoreboard and the decode/bypass logic.
package hazard_pkg;

  localparam int unsigned IR_W    = 32;
  localparam int unsigned FIELD_W = 5;

  localparam int unsigned OP_LSB  = 27;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS_LSB  = 17;
  localparam int unsigned RT_LSB  = 12;
  localparam int unsigned ALU_LSB = 2;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [FIELD_W-1:0] OP_LW    = 5'b01000;
  localparam logic [FIELD_W-1:0] OP_SW    = 5'b00111;

  localparam logic [FIELD_W-1:0] ALU_MUL = 5'b00110;
  localparam logic [FIELD_W-1:0] ALU_DIV = 5'b00111;

  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] rs;
    logic [FIELD_W-1:0] rt;
    logic [FIELD_W-1:0] aluop;
  } fields_t;

  typedef struct packed {
    logic    rtype;
    logic    lw;
    logic    sw;
    logic    muldiv;
    logic    writes_rd;
    fields_t f;
  } dec_t;

  function automatic dec_t decode(input logic [IR_W-1:0] ir);
    dec_t d;
    d.f.opcode  = ir[OP_LSB +: FIELD_W];
    d.f.rd      = ir[RD_LSB +: FIELD_W];
    d.f.rs      = ir[RS_LSB +: FIELD_W];
    d.f.rt      = ir[RT_LSB +: FIELD_W];
    d.f.aluop   = ir[ALU_LSB +: FIELD_W];
    d.rtype     = (d.f.opcode == OP_RTYPE);
    d.lw        = (d.f.opcode == OP_LW);
    d.sw        = (d.f.opcode == OP_SW);
    d.muldiv    = d.rtype && ((d.f.aluop == ALU_MUL) || (d.f.aluop == ALU_DIV));
    d.writes_rd = d.rtype || d.lw;
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for the single outstanding mult/div result.
// Clear-all takes effect before set so a back-to-back issue keeps only the new entry.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned REG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_all,
  output logic [NREG-1:0]  busy_vec,
  output logic             any_busy
);

  logic [NREG-1:0] busy_d, busy_q;
  logic            any_d, any_q;

  always_comb begin
    busy_d = clr_all ? '0 : busy_q;
    any_d  = clr_all ? 1'b0 : any_q;
    if (set_en) begin
      any_d = 1'b1;
      // r0 never carries a pending result
      if ((set_idx != '0) && (32'(set_idx) < NREG)) begin
        busy_d[set_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      any_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      any_q  <= any_d;
    end
  end

  assign busy_vec = busy_q;
  assign any_busy = any_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline stall generation: mult/div scoreboard hazards, stretched load-use
// stalls and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             md_start,
  input  logic             md_ready,
  output logic             stall,
  output logic             bubble,
  output logic             md_busy,
  output logic [NREG-1:0]  busy_vec,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned LuW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  dec_t fd, dx;
  assign fd = decode(fd_ir);
  assign dx = decode(dx_ir);

  logic unused_ir;
  assign unused_ir = ^{fd_ir, dx_ir, dx};

  reg_scoreboard #(
    .NREG  (NREG),
    .REG_W (REG_W)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .set_en   (md_start),
    .set_idx  (REG_W'(dx.f.rd)),
    .clr_all  (md_ready),
    .busy_vec (busy_vec),
    .any_busy (md_busy)
  );

  function automatic logic busy_at(input logic [NREG-1:0] vec, input logic [FIELD_W-1:0] r);
    return (r != '0) && (32'(r) < NREG) && vec[r];
  endfunction

  logic [LuW-1:0]   lu_d, lu_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             raw_md, waw_md, struct_md, md_hz, lu_src, lu_hit;

  always_comb begin
    // sw reads rd as store data: a pending mult/div result must not be stored early
    raw_md    = busy_at(busy_vec, fd.f.rs)
              | (fd.rtype & busy_at(busy_vec, fd.f.rt))
              | (fd.sw & busy_at(busy_vec, fd.f.rd));
    waw_md    = fd.writes_rd & busy_at(busy_vec, fd.f.rd);
    struct_md = fd.muldiv & md_busy;
    // writeback of the result is bypassed, so md_ready clears these hazards at once
    md_hz     = ~md_ready & (raw_md | waw_md | struct_md);

    // load data for a store is bypassed, so only the sw base register counts
    lu_src = (fd.f.rs == dx.f.rd) | (fd.rtype & (fd.f.rt == dx.f.rd));
    lu_hit = dx.lw & (dx.f.rd != '0) & lu_src & (lu_q == '0);

    stall = md_hz | lu_hit | (lu_q != '0);

    lu_d = lu_q;
    if (lu_q != '0) begin
      lu_d = lu_q - 1'b1;
    end else if (lu_hit) begin
      lu_d = LuW'(LOAD_LAT - 1);
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lu_q  <= '0;
      cnt_q <= '0;
    end else begin
      lu_q  <= lu_d;
      cnt_q <= cnt_d;
    end
  end

  assign bubble      = stall;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random checks of hazard_scoreboard against a register-level model,
// two instances: LOAD_LAT=3/CNT_W=8 and LOAD_LAT=1/CNT_W=4.
module tb_hazard_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fd_ir = '0;
  logic [31:0] dx_ir = '0;
  logic        md_start = 1'b0;
  logic        md_ready = 1'b0;

  logic        stall_a, bubble_a, md_busy_a, stall_b, bubble_b, md_busy_b;
  logic [31:0] busy_a, busy_b;
  logic [7:0]  cnt_a;
  logic [3:0]  cnt_b;

  always #5 clock = ~clock;

  hazard_scoreboard #(.NREG(32), .REG_W(5), .LOAD_LAT(3), .CNT_W(8)) ua (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .md_start(md_start), .md_ready(md_ready), .stall(stall_a), .bubble(bubble_a),
    .md_busy(md_busy_a), .busy_vec(busy_a), .stall_count(cnt_a)
  );

  hazard_scoreboard #(.NREG(32), .REG_W(5), .LOAD_LAT(1), .CNT_W(4)) ub (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .md_start(md_start), .md_ready(md_ready), .stall(stall_b), .bubble(bubble_b),
    .md_busy(md_busy_b), .busy_vec(busy_b), .stall_count(cnt_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model: at most one pending mult/div, remembered by its destination register
  bit m_busy;
  int m_dest;
  int lu[2];
  int cnt[2];
  int lat[2]  = '{3, 1};
  int cmax[2] = '{255, 15};
  bit exp_st[2];
  bit lu_dep;

  localparam int NOP = 0;

  function automatic logic [31:0] r_ir(int rd, int rs, int rt, int alu);
    return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'b00000, 5'(alu), 2'b00};
  endfunction

  function automatic logic [31:0] i_ir(int op, int rd, int rs, int imm);
    return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic int fld(logic [31:0] ir, int lsb);
    return int'((ir >> lsb) & 32'h1f);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic predict();
    int op, rd, rs, rt, alu, dop, drd;
    bit rty, lw, sw, md, md_hz;
    op  = fld(fd_ir, 27);
    rd  = fld(fd_ir, 22);
    rs  = fld(fd_ir, 17);
    rt  = fld(fd_ir, 12);
    alu = fld(fd_ir, 2);
    dop = fld(dx_ir, 27);
    drd = fld(dx_ir, 22);
    rty = (op == 0);
    lw  = (op == 8);
    sw  = (op == 7);
    md  = rty && (alu == 6 || alu == 7);
    md_hz = 1'b0;
    if (m_busy && !md_ready) begin
      if (m_dest != 0 && (rs == m_dest || (rty && rt == m_dest) || (sw && rd == m_dest)
                          || ((rty || lw) && rd == m_dest))) md_hz = 1'b1;
      if (md) md_hz = 1'b1;
    end
    lu_dep = (dop == 8) && drd != 0 && (rs == drd || (rty && rt == drd));
    for (int k = 0; k < 2; k++) exp_st[k] = md_hz || lu[k] > 0 || lu_dep;
  endtask

  task automatic update();
    if (reset) begin
      m_busy = 0; m_dest = 0;
      for (int k = 0; k < 2; k++) begin lu[k] = 0; cnt[k] = 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (exp_st[k] && cnt[k] < cmax[k]) cnt[k]++;
        if (lu[k] > 0) lu[k]--;
        else if (lu_dep) lu[k] = lat[k] - 1;
      end
      if (md_start) begin m_busy = 1; m_dest = fld(dx_ir, 22); end
      else if (md_ready) begin m_busy = 0; m_dest = 0; end
    end
  endtask

  task automatic step();
    logic [63:0] eb;
    #4;
    predict();
    eb = (m_dest != 0) ? (64'd1 << m_dest) : 64'd0;
    chk("stall_a", stall_a, exp_st[0]);
    chk("bubble_a", bubble_a, exp_st[0]);
    chk("stall_b", stall_b, exp_st[1]);
    chk("bubble_b", bubble_b, exp_st[1]);
    chk("md_busy_a", md_busy_a, m_busy);
    chk("md_busy_b", md_busy_b, m_busy);
    chk("busy_a", busy_a, eb);
    chk("busy_b", busy_b, eb);
    chk("cnt_a", cnt_a, cnt[0]);
    chk("cnt_b", cnt_b, cnt[1]);
    @(posedge clock);
    update();
    #1;
  endtask

  function automatic logic [31:0] rnd_ir();
    int r1, r2, r3;
    r1 = $urandom_range(7); r2 = $urandom_range(7); r3 = $urandom_range(7);
    case ($urandom_range(5))
      0: return r_ir(r1, r2, r3, 0);
      1: return r_ir(r1, r2, r3, 6);
      2: return r_ir(r1, r2, r3, 7);
      3: return i_ir(8, r1, r2, 4);
      4: return i_ir(7, r1, r2, 4);
      default: return i_ir(5, r1, r2, 1);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    @(posedge clock);
    update();
    #1;
    step();
    reset = 1'b0;

    // 1: independent instruction flows while mul r5 is outstanding
    dx_ir = r_ir(5, 1, 2, 6); md_start = 1; fd_ir = r_ir(6, 3, 4, 0);
    step();
    chk("t1_busy", busy_a, 64'h20);
    chk("t1_md_busy", md_busy_a, 1);
    md_start = 0; dx_ir = NOP;
    step();

    // 2: dependent add stalls until md_ready
    fd_ir = r_ir(7, 5, 1, 0);
    repeat (3) step();
    md_ready = 1;
    step();
    md_ready = 0;
    chk("t2_busy_clr", busy_a, 0);

    // 3: load-use stretch
    reset = 1; step(); reset = 0;
    dx_ir = i_ir(8, 4, 2, 0); fd_ir = r_ir(8, 4, 1, 0);
    step(); dx_ir = NOP; repeat (3) step();
    chk("t3_cnt_a_add", cnt_a, 3);
    chk("t3_cnt_b_add", cnt_b, 1);
    dx_ir = i_ir(8, 4, 2, 0); fd_ir = i_ir(7, 9, 4, 0);
    step(); dx_ir = NOP; repeat (3) step();
    chk("t3_cnt_a_swbase", cnt_a, 6);
    dx_ir = i_ir(8, 4, 2, 0); fd_ir = i_ir(7, 4, 9, 0);
    step(); dx_ir = NOP; repeat (3) step();
    chk("t3_cnt_a_swdata", cnt_a, 6);
    chk("t3_cnt_b_swdata", cnt_b, 2);

    // 4: div waits for the unit; ready and start on the same edge
    dx_ir = r_ir(3, 1, 2, 6); md_start = 1; fd_ir = NOP;
    step();
    md_start = 0; dx_ir = NOP; fd_ir = r_ir(10, 1, 2, 7);
    repeat (2) step();
    md_ready = 1; md_start = 1; dx_ir = r_ir(9, 1, 2, 6);
    step();
    chk("t4_busy", busy_a, 64'h200);
    chk("t4_md_busy", md_busy_a, 1);
    md_start = 0; dx_ir = NOP; fd_ir = NOP;
    step();
    md_ready = 0;

    // 5: r0 destinations never create hazards
    dx_ir = r_ir(0, 1, 2, 6); md_start = 1;
    step();
    chk("t5_busy", busy_a, 0);
    chk("t5_md_busy", md_busy_a, 1);
    md_start = 0; md_ready = 1; dx_ir = NOP;
    step();
    md_ready = 0;
    dx_ir = i_ir(8, 0, 1, 0); fd_ir = r_ir(1, 0, 0, 0);
    step();

    // 6: reset mid-stall
    dx_ir = r_ir(5, 1, 2, 6); md_start = 1; fd_ir = NOP;
    step();
    md_start = 0; dx_ir = i_ir(8, 4, 2, 0); fd_ir = r_ir(8, 4, 1, 0);
    step();
    reset = 1; dx_ir = NOP;
    step();
    reset = 0; fd_ir = NOP;
    #1;
    chk("t6_busy", busy_a, 0);
    chk("t6_stall", stall_a, 0);
    chk("t6_cnt", cnt_a, 0);
    step();

    // 6b: narrow counter saturates
    dx_ir = r_ir(5, 1, 2, 6); md_start = 1;
    step();
    md_start = 0; dx_ir = NOP; fd_ir = r_ir(7, 5, 1, 0);
    repeat (20) step();
    chk("t6_sat_b", cnt_b, 15);
    chk("t6_cnt_a", cnt_a, 20);
    md_ready = 1;
    step();
    md_ready = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(63) == 0);
      md_ready = m_busy ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      md_start = (!m_busy || md_ready) && ($urandom_range(3) == 0);
      dx_ir    = md_start ? r_ir($urandom_range(7), 1, 2, 6 + $urandom_range(1)) : rnd_ir();
      fd_ir    = rnd_ir();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
